// File: rtl/piso_tx_amisha.sv
// Parallel-in serial-out transmitter: valid/ready word load,
// one registered bit per clock, framed, with a last-bit done flag.
module piso_tx_amisha #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic [WIDTH-1:0] din_amisha,
  input  logic             load_valid_amisha,
  output logic             load_ready_amisha,
  output logic             sout_amisha,
  output logic             frame_amisha,
  output logic             done_amisha
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic             sout_nx;
  logic             frame_nx;
  logic             done_nx;
  logic             last;
  logic             accept;

  function automatic logic head(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0}
                     : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last   = (state == SHIFT) && (cnt == LAST);
  assign accept = load_valid_amisha && load_ready_amisha;

  // Ready during the last bit lets the next word follow with no gap.
  assign load_ready_amisha = (state == IDLE) || last;

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    sout_nx  = sout_amisha;
    frame_nx = frame_amisha;
    done_nx  = done_amisha;
    if (accept) begin
      state_nx = SHIFT;
      sout_nx  = head(din_amisha);
      sreg_nx  = adv(din_amisha);
      cnt_nx   = '0;
      frame_nx = 1'b1;
      done_nx  = 1'b0;
    end else begin
      unique case (state)
        SHIFT: begin
          if (last) begin
            state_nx = IDLE;
            sreg_nx  = '0;
            cnt_nx   = '0;
            sout_nx  = 1'b0;
            frame_nx = 1'b0;
            done_nx  = 1'b0;
          end else begin
            sout_nx  = head(sreg);
            sreg_nx  = adv(sreg);
            cnt_nx   = cnt + CW'(1);
            done_nx  = (cnt_nx == LAST);
          end
        end
        default: begin
          sout_nx  = 1'b0;
          frame_nx = 1'b0;
          done_nx  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state        <= IDLE;
      sreg         <= '0;
      cnt          <= '0;
      sout_amisha  <= 1'b0;
      frame_amisha <= 1'b0;
      done_amisha  <= 1'b0;
    end else begin
      state        <= state_nx;
      sreg         <= sreg_nx;
      cnt          <= cnt_nx;
      sout_amisha  <= sout_nx;
      frame_amisha <= frame_nx;
      done_amisha  <= done_nx;
    end
  end

endmodule

// File: tb/tb_piso_tx_amisha.sv
// Bench for piso_tx_amisha: MSB- and LSB-first instances against
// a bit-queue reference model, directed cases then random traffic.
module tb_piso_tx_amisha;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       vld;
  logic       rdy_m, sout_m, frame_m, done_m;
  logic       rdy_l, sout_l, frame_l, done_l;

  int checks = 0;
  int errors = 0;

  bit qm[$];
  bit ql[$];
  bit qd[$];

  piso_tx_amisha #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk_amisha        (clk),
    .rst_n_amisha      (rst_n),
    .din_amisha        (din),
    .load_valid_amisha (vld),
    .load_ready_amisha (rdy_m),
    .sout_amisha       (sout_m),
    .frame_amisha      (frame_m),
    .done_amisha       (done_m)
  );

  piso_tx_amisha #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk_amisha        (clk),
    .rst_n_amisha      (rst_n),
    .din_amisha        (din),
    .load_valid_amisha (vld),
    .load_ready_amisha (rdy_l),
    .sout_amisha       (sout_l),
    .frame_amisha      (frame_l),
    .done_amisha       (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic  got,
    input logic  exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t got=%b exp=%b",
               tag, $time, got, exp);
    end
  endtask

  task automatic chk_out(input bit with_rdy);
    bit on;
    on = (qm.size() > 0);
    chk("sout_m", sout_m, on ? qm[0] : 1'b0);
    chk("sout_l", sout_l, on ? ql[0] : 1'b0);
    chk("frame_m", frame_m, on);
    chk("frame_l", frame_l, on);
    chk("done_m", done_m, on ? qd[0] : 1'b0);
    chk("done_l", done_l, on ? qd[0] : 1'b0);
    if (with_rdy) begin
      chk("rdy_m", rdy_m, qm.size() <= 1);
      chk("rdy_l", rdy_l, qm.size() <= 1);
    end
  endtask

  // One clock: drive, check current outputs, advance the model.
  task automatic cycle(
    input logic       v,
    input logic [7:0] d
  );
    bit acc;
    vld = v;
    din = v ? d : 8'hxx;
    #1;
    chk_out(1'b1);
    acc = v && (qm.size() <= 1);
    @(posedge clk);
    if (qm.size() > 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
      void'(qd.pop_front());
    end
    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        qm.push_back(d[7-i]);
        ql.push_back(d[i]);
        qd.push_back(i == 7);
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset between edges, with load_valid asserted.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    vld   = 1'b1;
    din   = 8'($urandom);
    #1;
    qm.delete();
    ql.delete();
    qd.delete();
    chk_out(1'b0);
    @(posedge clk);
    #1;
    chk_out(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    vld   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    vld   = 1'b0;
    din   = 8'h00;
    repeat (2) @(negedge clk);
    chk_out(1'b0);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00);

    cycle(1'b1, 8'hA5);
    repeat (9) cycle(1'b0, 8'h00);

    cycle(1'b1, 8'h01);
    repeat (9) cycle(1'b0, 8'h00);

    cycle(1'b1, 8'hFF);
    repeat (7) cycle(1'b1, 8'h00);
    repeat (8) cycle(1'b1, 8'h00);
    repeat (8) cycle(1'b0, 8'h00);

    cycle(1'b1, 8'h3C);
    repeat (3) cycle(1'b0, 8'h00);
    async_reset();
    cycle(1'b1, 8'hC3);
    repeat (9) cycle(1'b0, 8'h00);

    repeat (20) cycle(1'b0, 8'h00);

    for (int n = 0; n < 400; n++) begin
      cycle(1'(($urandom % 3) != 0), 8'($urandom));
      if (n == 250) async_reset();
    end
    repeat (10) cycle(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
